// File: rtl/aes_pkg.sv
// Shared AES key-expansion types and constants.
package aes_pkg;

   localparam int unsigned KEY_WIDTH  = 128;
   localparam int unsigned NUM_ROUNDS = 10;
   localparam int unsigned ROUND_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DRAIN,
      EXPAND,
      READY
   } state_t;

endpackage

// File: rtl/key_expansion_ctrl_if.sv
// Key handshake, pipeline hold-off and key-generator drive bundle.
interface key_expansion_ctrl_if #(
   parameter int unsigned BLOCK_LENGTH = aes_pkg::KEY_WIDTH
);
   logic [BLOCK_LENGTH-1:0]       key_in;
   logic                          key_valid;
   logic                          key_ready;
   logic                          pipe_busy;
   logic                          kg_en;
   logic [aes_pkg::ROUND_W-1:0]   kg_round;
   logic [BLOCK_LENGTH-1:0]       kg_key;
   logic                          keys_valid;
   logic                          busy;
   logic                          done;

   modport slave (
      input  key_in, key_valid, pipe_busy,
      output key_ready, kg_en, kg_round, kg_key, keys_valid, busy, done
   );

   modport master (
      output key_in, key_valid, pipe_busy,
      input  key_ready, kg_en, kg_round, kg_key, keys_valid, busy, done
   );
endinterface

// File: rtl/key_expansion_ctrl.sv
// Key-expansion sequencer: latches a cipher key, waits for the pipeline to
// drain, then walks the key generator through rounds 0..NUM_ROUNDS.
// Optional feature macro: KEY_EXP_REUSE_EN (skip re-expanding an unchanged key).
module key_expansion_ctrl #(
   parameter int unsigned BLOCK_LENGTH = aes_pkg::KEY_WIDTH,
   parameter int unsigned NUM_ROUNDS   = aes_pkg::NUM_ROUNDS
) (
   input logic                 clk,
   input logic                 rst,
   key_expansion_ctrl_if.slave bus
);
   import aes_pkg::*;

   state_t                  r_state, w_state_nxt;
   logic [ROUND_W-1:0]      r_cnt, w_cnt_nxt;
   logic                    r_kg_en, w_kg_en_nxt;
   logic [ROUND_W-1:0]      r_kg_round, w_kg_round_nxt;
   logic [BLOCK_LENGTH-1:0] r_kg_key, w_kg_key_nxt;
   logic                    r_keys_valid, w_keys_valid_nxt;
   logic                    r_busy, w_busy_nxt;
   logic                    r_done, w_done_nxt;
   logic                    w_key_ready, w_accept, w_cnt_ok, w_cnt_last;
   logic                    w_hit, w_reuse_done;

   assign w_key_ready = (r_state == IDLE) || (r_state == READY);
   assign w_accept    = bus.key_valid && w_key_ready;
   assign w_cnt_ok    = r_cnt <= ROUND_W'(NUM_ROUNDS);
   assign w_cnt_last  = r_cnt == ROUND_W'(NUM_ROUNDS);

`ifdef KEY_EXP_REUSE_EN
   logic [BLOCK_LENGTH-1:0] r_last_key;
   logic                    r_reuse;

   assign w_hit        = (r_state == READY) && (bus.key_in == r_last_key);
   assign w_reuse_done = r_reuse;

   // Remember the key once its expansion completes; flag skipped expansions
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_key <= '0;
         r_reuse    <= 1'b0;
      end else begin
         if ((r_state == EXPAND) && (w_state_nxt == READY))
            r_last_key <= r_kg_key;
         r_reuse <= w_accept && w_hit;
      end
   end
`else
   assign w_hit        = 1'b0;
   assign w_reuse_done = 1'b0;
`endif

   // Next state, round counter and next values of the registered outputs
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_kg_en_nxt      = (r_state == EXPAND) && w_cnt_ok;
      w_kg_round_nxt   = w_kg_en_nxt ? r_cnt : '0;
      w_kg_key_nxt     = r_kg_key;
      w_keys_valid_nxt = r_keys_valid;
      w_done_nxt       = w_reuse_done;

      // kg_en still high in READY means the final round is being stored now
      if ((r_state == READY) && r_kg_en) begin
         w_done_nxt       = 1'b1;
         w_keys_valid_nxt = 1'b1;
      end

      case (r_state)
         IDLE, READY: begin
            if (w_accept) begin
               w_kg_key_nxt = bus.key_in;
               if (w_hit) begin
                  w_keys_valid_nxt = 1'b1;
               end else begin
                  w_keys_valid_nxt = 1'b0;
                  w_cnt_nxt        = '0;
                  w_state_nxt      = bus.pipe_busy ? WAIT_DRAIN : EXPAND;
               end
            end
         end
         WAIT_DRAIN: begin
            if (!bus.pipe_busy) begin
               w_state_nxt = EXPAND;
               w_cnt_nxt   = '0;
            end
         end
         EXPAND: begin
            if (!w_cnt_ok) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (w_cnt_last) begin
               w_state_nxt = READY;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = ROUND_W'(r_cnt + 1'b1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      w_busy_nxt = (w_state_nxt == WAIT_DRAIN) || (w_state_nxt == EXPAND);
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_kg_en      <= 1'b0;
         r_kg_round   <= '0;
         r_kg_key     <= '0;
         r_keys_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_kg_en      <= w_kg_en_nxt;
         r_kg_round   <= w_kg_round_nxt;
         r_kg_key     <= w_kg_key_nxt;
         r_keys_valid <= w_keys_valid_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
      end
   end

   assign bus.key_ready  = w_key_ready;
   assign bus.kg_en      = r_kg_en;
   assign bus.kg_round   = r_kg_round;
   assign bus.kg_key     = r_kg_key;
   assign bus.keys_valid = r_keys_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed bench for key_expansion_ctrl with a small AES key-schedule model
// standing in for the key generator.
module tb_key_expansion_ctrl;

   localparam logic [127:0] K1     = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] K1_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] K2     = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] K2_R10 = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_expansion_ctrl_if #(.BLOCK_LENGTH(128)) kif ();

   key_expansion_ctrl #(.BLOCK_LENGTH(128), .NUM_ROUNDS(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (kif)
   );

   int n_chk = 0;
   int n_fail = 0;
   int en_cnt = 0;
   int seq_err = 0;
   int done_cnt = 0;
   int kv_low = 0;
   logic [127:0] rk = '0;
   logic [127:0] k10 = '0;

   // Key-schedule model
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
      logic [7:0]  rc;
      logic [31:0] t, w3, n0, n1, n2, n3;
      rc = 8'h01;
      for (int i = 1; i < r; i++) rc = xt(rc);
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Generator stand-in and sequence observer, sampled mid-cycle
   always @(negedge clk) begin
      if (kif.kg_en) begin
         if (int'(kif.kg_round) != en_cnt) seq_err++;
         rk = (kif.kg_round == 4'd0) ? kif.kg_key : next_rk(rk, int'(kif.kg_round));
         if (kif.kg_round == 4'd10) k10 = rk;
         en_cnt++;
      end else if (kif.kg_round != 4'd0) begin
         seq_err++;
      end
      if (kif.done) done_cnt++;
      if (!kif.keys_valid) kv_low++;
   end

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [127:0] key, input logic pbusy);
      kif.key_in    = key;
      kif.key_valid = 1'b1;
      kif.pipe_busy = pbusy;
      tick(1);
      kif.key_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".kg_en"},      kif.kg_en,      1'b0);
      chk({tag, ".kg_round"},   kif.kg_round,   4'd0);
      chk({tag, ".kg_key"},     kif.kg_key,     128'h0);
      chk({tag, ".keys_valid"}, kif.keys_valid, 1'b0);
      chk({tag, ".busy"},       kif.busy,       1'b0);
      chk({tag, ".done"},       kif.done,       1'b0);
      chk({tag, ".key_ready"},  kif.key_ready,  1'b1);
   endtask

   initial begin
      rst           = 1'b0;
      kif.key_in    = '0;
      kif.key_valid = 1'b0;
      kif.pipe_busy = 1'b0;
      #3;
      chk_reset_vals("por");
      tick(2);
      rst = 1'b1;
      tick(1);

      // Basic expansion of K1 with the pipeline idle
      en_cnt = 0; done_cnt = 0; seq_err = 0;
      accept(K1, 1'b0);
      chk("t1.kg_key",    kif.kg_key,    K1);
      chk("t1.busy",      kif.busy,      1'b1);
      chk("t1.key_ready", kif.key_ready, 1'b0);
      chk("t1.kg_en_n0",  kif.kg_en,     1'b0);
      tick(1);
      chk("t1.kg_en_n1",  kif.kg_en,     1'b1);
      chk("t1.round_n1",  kif.kg_round,  4'd0);
      tick(10);
      chk("t1.kg_en_n11", kif.kg_en,     1'b1);
      chk("t1.round_n11", kif.kg_round,  4'd10);
      chk("t1.kv_n11",    kif.keys_valid, 1'b0);
      chk("t1.done_n11",  kif.done,      1'b0);
      tick(1);
      chk("t1.kg_en_n12", kif.kg_en,     1'b0);
      chk("t1.done_n12",  kif.done,      1'b1);
      chk("t1.kv_n12",    kif.keys_valid, 1'b1);
      chk("t1.busy_n12",  kif.busy,      1'b0);
      chk("t1.ready_n12", kif.key_ready, 1'b1);
      tick(1);
      chk("t1.done_n13",  kif.done,      1'b0);
      chk("t1.kv_n13",    kif.keys_valid, 1'b1);
      chk("t1.en_cycles", en_cnt,        11);
      chk("t1.seq",       seq_err,       0);
      chk("t1.k10",       k10,           K1_R10);
      chk("t1.done_cnt",  done_cnt,      1);

      // Accept K2 while the pipeline is busy for 5 cycles
      en_cnt = 0; done_cnt = 0;
      accept(K2, 1'b1);
      chk("t2.kv_drop",   kif.keys_valid, 1'b0);
      chk("t2.busy",      kif.busy,      1'b1);
      chk("t2.kg_key",    kif.kg_key,    K2);
      tick(4);
      kif.pipe_busy = 1'b0;
      chk("t2.kg_en_hold", kif.kg_en,    1'b0);
      chk("t2.en_hold",   en_cnt,        0);
      tick(1);
      chk("t2.kg_en_e",   kif.kg_en,     1'b0);
      tick(1);
      chk("t2.kg_en_e1",  kif.kg_en,     1'b1);
      chk("t2.round_e1",  kif.kg_round,  4'd0);
      tick(11);
      chk("t2.done",      kif.done,      1'b1);
      chk("t2.kv",        kif.keys_valid, 1'b1);
      tick(1);
      chk("t2.en_cycles", en_cnt,        11);
      chk("t2.k10",       k10,           K2_R10);
      chk("t2.seq",       seq_err,       0);

      // Second key offered during EXPAND waits for READY
      en_cnt = 0; done_cnt = 0;
      accept(K1, 1'b0);
      tick(3);
      kif.key_in    = K2;
      kif.key_valid = 1'b1;
      tick(1);
      chk("t3.ready_exp", kif.key_ready, 1'b0);
      chk("t3.key_hold",  kif.kg_key,    K1);
      tick(7);
      chk("t3.key_a11",   kif.kg_key,    K1);
      chk("t3.round_a11", kif.kg_round,  4'd10);
      tick(1);
      kif.key_valid = 1'b0;
      chk("t3.key_a12",   kif.kg_key,    K2);
      chk("t3.done_a12",  kif.done,      1'b1);
      chk("t3.kv_a12",    kif.keys_valid, 1'b0);
      chk("t3.en_first",  en_cnt,        11);
      chk("t3.k10_first", k10,           K1_R10);
      en_cnt = 0;
      tick(12);
      chk("t3.done_2",    kif.done,      1'b1);
      chk("t3.kv_2",      kif.keys_valid, 1'b1);
      chk("t3.key_2",     kif.kg_key,    K2);
      tick(1);
      chk("t3.en_second", en_cnt,        11);
      chk("t3.k10_second", k10,          K2_R10);
      chk("t3.done_cnt",  done_cnt,      2);

      // Reset during round 5, then a full expansion again
      en_cnt = 0; done_cnt = 0;
      accept(K1, 1'b0);
      tick(6);
      chk("t4.kg_en_r5",  kif.kg_en,     1'b1);
      chk("t4.round_r5",  kif.kg_round,  4'd5);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_vals("t4.rst");
      tick(2);
      rst = 1'b1;
      tick(3);
      chk("t4.no_done",   done_cnt,      0);
      chk("t4.kv_low",    kif.keys_valid, 1'b0);
      en_cnt = 0;
      accept(K1, 1'b0);
      tick(12);
      chk("t4.done",      kif.done,      1'b1);
      chk("t4.kv",        kif.keys_valid, 1'b1);
      tick(1);
      chk("t4.en_cycles", en_cnt,        11);
      chk("t4.k10",       k10,           K1_R10);

      // Re-accept of the same key in READY
      en_cnt = 0; done_cnt = 0; kv_low = 0;
`ifdef KEY_EXP_REUSE_EN
      accept(K1, 1'b0);
      chk("t5.kg_en",     kif.kg_en,     1'b0);
      chk("t5.kv",        kif.keys_valid, 1'b1);
      chk("t5.done_c",    kif.done,      1'b0);
      chk("t5.busy",      kif.busy,      1'b0);
      chk("t5.ready",     kif.key_ready, 1'b1);
      tick(1);
      chk("t5.done_c1",   kif.done,      1'b1);
      tick(2);
      chk("t5.done_off",  kif.done,      1'b0);
      chk("t5.en_cycles", en_cnt,        0);
      chk("t5.kv_low",    kv_low,        0);
      chk("t5.done_cnt",  done_cnt,      1);
      accept(K2, 1'b0);
      chk("t5.kv_drop",   kif.keys_valid, 1'b0);
      tick(12);
      chk("t5.done_k2",   kif.done,      1'b1);
      tick(1);
      chk("t5.en_k2",     en_cnt,        11);
      chk("t5.k10_k2",    k10,           K2_R10);
`else
      accept(K1, 1'b0);
      chk("t5.kv_drop",   kif.keys_valid, 1'b0);
      chk("t5.busy",      kif.busy,      1'b1);
      tick(12);
      chk("t5.done",      kif.done,      1'b1);
      chk("t5.kv",        kif.keys_valid, 1'b1);
      tick(1);
      chk("t5.en_cycles", en_cnt,        11);
      chk("t5.k10",       k10,           K1_R10);
`endif
      chk("final.seq",    seq_err,       0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/key_expansion_ctrl.md
# key_expansion_ctrl

Sequencer for the encryption key generator. It accepts a 128-bit cipher key over a valid/ready handshake and holds it stable for the generator. It then drives the generator's enable and round index through rounds 0..10, one per cycle, and flags when all eleven round keys are stored. It also holds off re-keying while the encryption pipeline is still consuming the current round keys.

## Interface
Parameters:
- BLOCK_LENGTH, 128, key width in bits.
- NUM_ROUNDS, 10, last round index driven on kg_round.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- key_in  in  BLOCK_LENGTH  cipher key, sampled on accept.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  controller can accept a key.
- pipe_busy  in  1  encryption pipeline is using the round-key registers.
- kg_en  out  1  enable to the key generator.
- kg_round  out  4  round index to the key generator.
- kg_key  out  BLOCK_LENGTH  latched key to the key generator.
- keys_valid  out  1  all round keys are stored and stable.
- busy  out  1  controller is in WAIT_DRAIN or EXPAND.
- done  out  1  one-cycle pulse when an expansion completes.

## Operation
- States and outputs:
  - IDLE: key_ready=1.
  - WAIT_DRAIN: waiting for pipe_busy=0.
  - EXPAND: kg_en=1, kg_round=counter.
  - READY: key_ready=1, keys_valid=1.
- Accept is key_valid && key_ready at a clk edge.
- On accept:
  - kg_key <= key_in.
  - keys_valid <= 0 on the same edge.
  - Next state is WAIT_DRAIN if pipe_busy=1, else EXPAND with counter=0.
- WAIT_DRAIN: pipe_busy is sampled each cycle. On pipe_busy=0, go to EXPAND with counter=0.
- EXPAND:
  - The counter increments by 1 per cycle, 0..NUM_ROUNDS.
  - At counter==NUM_ROUNDS, the next state is READY, done pulses and keys_valid is set.
  - No wrap-around: the counter never exceeds NUM_ROUNDS. Values 11..15 are unreachable; if forced, the controller returns to IDLE.
- key_ready=0 in WAIT_DRAIN and EXPAND. A pending key_valid must be held by upstream and is not lost.
- pipe_busy is ignored in EXPAND and READY. The pipeline must not start while keys_valid=0.
- kg_key is stable from accept until the next accept.
- When kg_en=0, kg_round is 0.

## Timing
- Reset values (asynchronous, immediate):
  - IDLE, counter=0.
  - kg_en=0, kg_round=0, kg_key=0.
  - keys_valid=0, busy=0, done=0.
  - key_ready=1, decoded from IDLE.
- Accept at edge N with pipe_busy=0:
  - kg_en=1 in cycles N+1..N+11, with kg_round=0..10.
  - keys_valid=1 and done=1 from edge N+12. done lasts one cycle.
- Accept with pipe_busy=1: expansion starts one cycle after the first edge that samples pipe_busy=0.
- All outputs are registered except key_ready, which is a state decode.
- Reset mid-expansion: immediate return to IDLE, keys_valid=0, no done pulse.
- Accept in READY: keys_valid falls on the accept edge and a fresh expansion follows.

## Configuration
- KEY_EXP_REUSE_EN defined:
  - The controller keeps the last fully expanded key.
  - An accept in READY with key_in equal to that key skips expansion.
  - The state stays READY, keys_valid stays 1, kg_en stays 0, and done pulses on the next cycle.
  - An expansion aborted by reset does not update the stored key.
- Undefined: every accept performs a full expansion, and no comparator or storage is built.

## Structure
- Shared package aes_pkg holds:
  - the state enum {IDLE, WAIT_DRAIN, EXPAND, READY};
  - NUM_ROUNDS and KEY_WIDTH constants.
- No sub-module: a single FSM with a 4-bit counter.
- Instantiated beside key_generator in the encryption top. kg_en, kg_round and kg_key connect to the generator's en, Round_Count and key.

## Test plan
- Reset, then accept key 2b7e1516_28aed2a6_abf71588_09cf4f3c with pipe_busy=0:
  - kg_en high exactly 11 cycles, kg_round 0..10.
  - done and keys_valid at N+12.
  - Generator k10 equals d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- Accept while pipe_busy=1 for 5 cycles: kg_en stays 0 throughout, and expansion starts one cycle after pipe_busy falls.
- key_valid asserted during EXPAND with a second key: not accepted until READY. The second key is then expanded and kg_key changes only at that accept.
- rst low at round 5: all outputs at reset values immediately. After release, a new accept performs a full 11-cycle expansion.
- KEY_EXP_REUSE_EN:
  - Re-accepting the same key in READY gives zero kg_en cycles, a done pulse and no drop in keys_valid.
  - A different key gives a full expansion.
